// File: rtl/rtm_c2d_sched_pkg.sv
// Shared types and default parameters for the RTM-to-DRAM store scheduler.
package rtm_c2d_sched_pkg;

    localparam int unsigned ROW_SHIFT       = 6;
    localparam int unsigned CHUNK_SHIFT     = 12;
    localparam int unsigned ROW_BYTES_DEF   = 1 << ROW_SHIFT;
    localparam int unsigned MAX_CHUNK_DEF   = 1 << CHUNK_SHIFT;
    localparam int unsigned QUEUE_DEPTH_DEF = 4;
    localparam int unsigned DEPTH_W_DEF     = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT
    } state_t;

    // Queued store instruction; c_addr is the RTM row zero-extended to 32 bits.
    typedef struct packed {
        logic [31:0] d_addr;
        logic [31:0] c_addr;
        logic [31:0] n_bytes;
    } ins_t;

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/rtm_c2d_sched_if.sv
// Instruction-decoder and writeback-engine signals of the store scheduler.
interface rtm_c2d_sched_if
    import rtm_c2d_sched_pkg::*;
#(
    parameter int unsigned DEPTH_W = DEPTH_W_DEF
);
    logic               ins_valid;
    logic               ins_ready;
    logic [31:0]        ins_d_addr;
    logic [DEPTH_W-1:0] ins_c_addr;
    logic [31:0]        ins_n_bytes;
    logic               ins_done_pulse;
    logic               c2d_start_pulse;
    logic [31:0]        c2d_d_addr;
    logic [31:0]        c2d_c_addr;
    logic [31:0]        c2d_n_bytes;
    logic               c2d_done_pulse;

    modport master (
        output ins_valid, ins_d_addr, ins_c_addr, ins_n_bytes, c2d_done_pulse,
        input  ins_ready, ins_done_pulse, c2d_start_pulse, c2d_d_addr, c2d_c_addr, c2d_n_bytes
    );

    modport slave (
        input  ins_valid, ins_d_addr, ins_c_addr, ins_n_bytes, c2d_done_pulse,
        output ins_ready, ins_done_pulse, c2d_start_pulse, c2d_d_addr, c2d_c_addr, c2d_n_bytes
    );
endinterface

// File: rtl/rtm_c2d_sched_queue.sv
// Show-ahead instruction FIFO with count-based full/empty and registered ready.
module rtm_c2d_sched_queue
    import rtm_c2d_sched_pkg::*;
#(
    parameter int unsigned DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  ins_t din,
    output logic ready,
    input  logic pop,
    output ins_t dout,
    output logic empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ins_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && ready;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Flags are computed from the next count so they are exact in the cycle after each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            ready <= (count_nxt != CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/rtm_c2d_sched.sv
// Store-instruction scheduler: splits queued stores into engine-sized chunks.
// Optional perf counters are built when RTM_C2D_SCHED_PERF_EN is defined.
module rtm_c2d_sched
    import rtm_c2d_sched_pkg::*;
#(
    parameter int unsigned ROW_BYTES       = ROW_BYTES_DEF,
    parameter int unsigned MAX_CHUNK_BYTES = MAX_CHUNK_DEF,
    parameter int unsigned QUEUE_DEPTH     = QUEUE_DEPTH_DEF,
    parameter int unsigned DEPTH_W         = DEPTH_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    rtm_c2d_sched_if.slave     bus,
    output logic               busy,
    output logic               err_align,
    output logic               err_spurious,
    input  logic               err_clr
`ifdef RTM_C2D_SCHED_PERF_EN
    ,
    input  logic               perf_clr,
    output logic [31:0]        perf_busy_cycles,
    output logic [31:0]        perf_wait_cycles
`endif
);
    localparam int unsigned RS        = $clog2(ROW_BYTES);
    localparam logic [31:0] MAX_CHUNK = 32'(MAX_CHUNK_BYTES);

    state_t      state;
    logic [31:0] rem;
    logic [31:0] d_addr;
    logic [31:0] c_addr;
    ins_t        q_din;
    ins_t        q_dout;
    logic        q_empty;
    logic        pop_c;
    logic        align_err_c;

    assign q_din       = '{d_addr: bus.ins_d_addr, c_addr: 32'(bus.ins_c_addr), n_bytes: bus.ins_n_bytes};
    assign pop_c       = (state == ST_IDLE) && !q_empty;
    assign align_err_c = (state == ST_LOAD) && (rem != '0) && (rem[RS-1:0] != '0);
    assign busy        = (state != ST_IDLE) || !q_empty;

    rtm_c2d_sched_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.ins_valid),
        .din   (q_din),
        .ready (bus.ins_ready),
        .pop   (pop_c),
        .dout  (q_dout),
        .empty (q_empty)
    );

    // Chunk length lives in c2d_n_bytes, which stays stable until the next issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= ST_IDLE;
            rem                 <= '0;
            d_addr              <= '0;
            c_addr              <= '0;
            bus.c2d_start_pulse <= 1'b0;
            bus.c2d_d_addr      <= '0;
            bus.c2d_c_addr      <= '0;
            bus.c2d_n_bytes     <= '0;
            bus.ins_done_pulse  <= 1'b0;
        end else begin
            bus.c2d_start_pulse <= 1'b0;
            bus.ins_done_pulse  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        rem    <= q_dout.n_bytes;
                        d_addr <= q_dout.d_addr;
                        c_addr <= q_dout.c_addr;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (rem == '0 || rem[RS-1:0] != '0) begin
                        bus.ins_done_pulse <= 1'b1;
                        state              <= ST_IDLE;
                    end else begin
                        bus.c2d_start_pulse <= 1'b1;
                        bus.c2d_d_addr      <= d_addr;
                        bus.c2d_c_addr      <= c_addr;
                        bus.c2d_n_bytes     <= min_u32(rem, MAX_CHUNK);
                        state               <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (bus.c2d_done_pulse) begin
                        // Last chunk: completion shows during NEXT, one cycle after done.
                        if (rem == bus.c2d_n_bytes) bus.ins_done_pulse <= 1'b1;
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    d_addr <= d_addr + bus.c2d_n_bytes;
                    c_addr <= 32'(DEPTH_W'(c_addr + (bus.c2d_n_bytes >> RS)));
                    rem    <= rem - bus.c2d_n_bytes;
                    state  <= (rem != bus.c2d_n_bytes) ? ST_LOAD : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_align    <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (align_err_c)  err_align <= 1'b1;
            else if (err_clr) err_align <= 1'b0;
            if (bus.c2d_done_pulse && state != ST_WAIT) err_spurious <= 1'b1;
            else if (err_clr)                           err_spurious <= 1'b0;
        end
    end

`ifdef RTM_C2D_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cycles <= '0;
            perf_wait_cycles <= '0;
        end else if (perf_clr) begin
            perf_busy_cycles <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (busy && perf_busy_cycles != '1)
                perf_busy_cycles <= perf_busy_cycles + 32'(1);
            if (state == ST_WAIT && perf_wait_cycles != '1)
                perf_wait_cycles <= perf_wait_cycles + 32'(1);
        end
    end
`endif
endmodule

// File: tb/tb_rtm_c2d_sched.sv
// Scoreboard bench for rtm_c2d_sched: directed stores, engine model, error and reset cases.
module tb_rtm_c2d_sched;

    typedef struct {
        logic [31:0] d;
        logic [31:0] c;
        logic [31:0] n;
        int          lat;
    } exp_start_t;

    typedef struct {
        int starts;
        bit lat;
    } exp_done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, err_align, err_spurious;
    logic err_clr = 1'b0;
    logic eng_done = 1'b0;
    logic spur_done = 1'b0;
`ifdef RTM_C2D_SCHED_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] perf_busy_cycles, perf_wait_cycles;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cyc = 0;
    int timer = 0;
    int done_delay = 3;
    int act_starts = 0;
    int exp_starts = 0;
    bit hold_done = 1'b0;
    bit e_acc = 1'b0;

    exp_start_t q_start[$];
    exp_done_t  q_done[$];

    rtm_c2d_sched_if #(.DEPTH_W(12)) bus ();

    assign bus.c2d_done_pulse = eng_done | spur_done;

    rtm_c2d_sched #(
        .ROW_BYTES(64), .MAX_CHUNK_BYTES(4096), .QUEUE_DEPTH(4), .DEPTH_W(12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .err_align    (err_align),
        .err_spurious (err_spurious),
        .err_clr      (err_clr)
`ifdef RTM_C2D_SCHED_PERF_EN
        ,
        .perf_clr         (perf_clr),
        .perf_busy_cycles (perf_busy_cycles),
        .perf_wait_cycles (perf_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic exp_s(input logic [31:0] d, input logic [31:0] c, input logic [31:0] n, input int lat);
        q_start.push_back('{d: d, c: c, n: n, lat: lat});
        exp_starts++;
    endtask

    task automatic exp_d(input bit lat);
        q_done.push_back('{starts: exp_starts, lat: lat});
    endtask

    task automatic push(input logic [31:0] d, input logic [11:0] c, input logic [31:0] n);
        bus.ins_valid   = 1'b1;
        bus.ins_d_addr  = d;
        bus.ins_c_addr  = c;
        bus.ins_n_bytes = n;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.ins_ready) begin
                @(posedge clk);
                #1;
                bus.ins_valid = 1'b0;
                return;
            end
        end
        bus.ins_valid = 1'b0;
        fail_now("push_timeout");
    endtask

    task automatic drain();
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            if (q_start.size() == 0 && q_done.size() == 0 && !busy) return;
        end
        fail_now("drain_timeout");
    endtask

    task automatic pulse_err(input bit clr, input bit spur);
        err_clr   = clr;
        spur_done = spur;
        @(posedge clk);
        #1;
        err_clr   = 1'b0;
        spur_done = 1'b0;
    endtask

    // Engine model and scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        exp_start_t es;
        exp_done_t  ed;
        cyc++;
        if (rst) begin
            timer    = 0;
            eng_done = 1'b0;
        end else begin
            eng_done = 1'b0;
            if (timer == -1 && !hold_done) begin
                timer = done_delay;
            end else if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    eng_done = 1'b1;
                    done_cyc = cyc;
                end
            end
            if (bus.ins_valid && bus.ins_ready) acc_cyc = cyc;
            if (bus.c2d_start_pulse) begin
                act_starts++;
                if (q_start.size() == 0) begin
                    fail_now("unexpected_start");
                end else begin
                    es = q_start.pop_front();
                    chk("start_d_addr", bus.c2d_d_addr, es.d);
                    chk("start_c_addr", bus.c2d_c_addr, es.c);
                    chk("start_n_bytes", bus.c2d_n_bytes, es.n);
                    if (es.lat >= 0) chk("accept_to_start", 32'(cyc - acc_cyc), 32'(es.lat));
                end
                timer = hold_done ? -1 : done_delay;
            end
            if (bus.ins_done_pulse) begin
                if (q_done.size() == 0) begin
                    fail_now("unexpected_ins_done");
                end else begin
                    ed = q_done.pop_front();
                    chk("starts_before_done", 32'(act_starts), 32'(ed.starts));
                    if (ed.lat) chk("done_to_ins_done", 32'(cyc - done_cyc), 32'd1);
                end
            end
        end
    end

    initial begin
        bus.ins_valid   = 1'b0;
        bus.ins_d_addr  = '0;
        bus.ins_c_addr  = '0;
        bus.ins_n_bytes = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ins_ready", bus.ins_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", bus.c2d_start_pulse, 0);
        chk("rst_ins_done", bus.ins_done_pulse, 0);
        chk("rst_c2d_d_addr", bus.c2d_d_addr, 0);
        chk("rst_c2d_n_bytes", bus.c2d_n_bytes, 0);
        chk("rst_err_align", err_align, 0);
        chk("rst_err_spurious", err_spurious, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 10240 bytes -> 4096 + 4096 + 2048
        exp_s(32'h1000_0000, 32'h010, 32'd4096, 3);
        exp_s(32'h1000_1000, 32'h050, 32'd4096, -1);
        exp_s(32'h1000_2000, 32'h090, 32'd2048, -1);
        exp_d(1);
        push(32'h1000_0000, 12'h010, 32'd10240);
        drain();

        // Engine stalled on X; queue fills with A..D, E waits for the first pop.
        hold_done = 1'b1;
        exp_s(32'h2000_0000, 32'h000, 32'd4096, -1); exp_d(1);
        push(32'h2000_0000, 12'h000, 32'd4096);
        repeat (8) @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            exp_s(32'h2000_0000 + 32'(i) * 32'h100, 32'(i), 32'd64, -1);
            exp_d(1);
            push(32'h2000_0000 + 32'(i) * 32'h100, 12'(i), 32'd64);
        end
        chk("ready_low_after_4", bus.ins_ready, 0);
        exp_s(32'h2000_0500, 32'h005, 32'd128, -1); exp_d(1);
        e_acc = 1'b0;
        fork
            begin
                push(32'h2000_0500, 12'h005, 32'd128);
                e_acc = 1'b1;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("ready_still_low", bus.ins_ready, 0);
                chk("fifth_held", 32'(e_acc), 0);
                hold_done = 1'b0;
            end
        join
        drain();

        // Zero-length store: completion without any engine start.
        exp_d(0);
        push(32'h5000_0000, 12'h000, 32'd0);
        drain();
        chk("zero_no_align_err", err_align, 0);

        // Unaligned length: dropped with completion, sticky error until cleared.
        exp_d(0);
        push(32'h5000_0000, 12'h000, 32'd100);
        drain();
        chk("align_err_set", err_align, 1);
        pulse_err(1'b1, 1'b0);
        chk("align_err_cleared", err_align, 0);

        // Row address wraps at 2^12 and DRAM address wraps at 2^32.
        exp_s(32'hFFFF_F000, 32'hFC0, 32'd4096, -1);
        exp_s(32'h0000_0000, 32'h000, 32'd4096, -1);
        exp_d(1);
        push(32'hFFFF_F000, 12'hFC0, 32'd8192);
        drain();
        chk("no_spurious_yet", err_spurious, 0);
        pulse_err(1'b0, 1'b1);
        chk("spurious_in_idle", err_spurious, 1);
        pulse_err(1'b1, 1'b0);
        chk("spurious_cleared", err_spurious, 0);
        pulse_err(1'b1, 1'b1);
        chk("set_wins_over_clr", err_spurious, 1);
        pulse_err(1'b1, 1'b0);
        chk("spurious_cleared2", err_spurious, 0);

        // Reset while the engine transfer is outstanding.
        hold_done = 1'b1;
        exp_s(32'h6000_0000, 32'h020, 32'd4096, -1);
        push(32'h6000_0000, 12'h020, 32'd4096);
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ins_ready", bus.ins_ready, 1);
        chk("midrst_start", bus.c2d_start_pulse, 0);
        chk("midrst_c2d_d_addr", bus.c2d_d_addr, 0);
        chk("midrst_c2d_c_addr", bus.c2d_c_addr, 0);
        chk("midrst_c2d_n_bytes", bus.c2d_n_bytes, 0);
        q_done.delete();
        hold_done = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        pulse_err(1'b0, 1'b1);
        chk("late_done_spurious", err_spurious, 1);
        pulse_err(1'b1, 1'b0);
        exp_s(32'h7000_0040, 32'h005, 32'd192, 3);
        exp_d(1);
        push(32'h7000_0040, 12'h005, 32'd192);
        drain();

`ifdef RTM_C2D_SCHED_PERF_EN
        done_delay = 20;
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        exp_s(32'h8000_0000, 32'h000, 32'd4096, -1);
        exp_d(1);
        push(32'h8000_0000, 12'h000, 32'd4096);
        drain();
        chk("perf_wait_cycles", perf_wait_cycles, 32'd20);
        chk("perf_busy_cycles", perf_busy_cycles, 32'd24);
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        chk("perf_wait_clr", perf_wait_cycles, 0);
        chk("perf_busy_clr", perf_busy_cycles, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("final_starts", 32'(act_starts), 32'(exp_starts));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
